// File: rtl/xpt_sequencer.sv
// xpt_sequencer: T-state sequencer that runs the M1 opcode fetch, latches opcode/prefix
// and steps the XPT counter for the downstream opcode decoders.
module xpt_sequencer #(
    parameter int XPT_W      = 5,
    parameter int FETCH_LAST = 2,
    parameter int XPT_MAX    = 31
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WAIT,
    input  logic [7:0]       DataIn,
    input  logic             PR_Reset_XPT,
    input  logic             P2_Set_CM1,
    input  logic             Pa_Ophd,
    output logic [XPT_W-1:0] XPT,
    output logic [XPT_W-1:0] notXPT,
    output logic             CM1,
    output logic [7:0]       OP,
    output logic [1:0]       PREFIX,
    output logic             IX_nIY,
    output logic             Decode_Enable,
    output logic             XPT_Overflow
);
    typedef enum logic {S_FETCH, S_EXEC} state_t;
    state_t           r_state;
    logic [XPT_W-1:0] r_xpt;
    logic [XPT_W-1:0] r_nxpt;
    logic             r_cm1;
    logic [7:0]       r_op;
    logic [1:0]       r_prefix;
    logic             r_ix;
    logic             r_de;
    logic             r_ovf;
    logic             w_at_last;
    logic             w_at_max;
    logic             w_is_pfx;
    logic             w_recover;
    logic [XPT_W-1:0] w_xpt_inc;
    logic [XPT_W-1:0] w_xpt_nxt;
    assign w_at_last = r_xpt == XPT_W'(FETCH_LAST);
    assign w_at_max  = r_xpt == XPT_W'(XPT_MAX);
    assign w_is_pfx  = DataIn inside {8'hCB, 8'hED, 8'hDD, 8'hFD};
    assign w_recover = !P2_Set_CM1 && !PR_Reset_XPT && w_at_max;
    assign w_xpt_inc = r_xpt + 1'b1;
    // notXPT is registered from the same next value so the pair can never disagree
    assign w_xpt_nxt = WAIT ? r_xpt
                     : (r_state == S_FETCH) ? ((w_at_last && w_is_pfx) ? '0 : w_xpt_inc)
                     : ((P2_Set_CM1 || PR_Reset_XPT || w_at_max) ? '0 : w_xpt_inc);
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_FETCH;
            r_xpt    <= '0;
            r_nxpt   <= '1;
            r_cm1    <= 1'b1;
            r_op     <= 8'h00;
            r_prefix <= 2'b00;
            r_ix     <= 1'b0;
            r_de     <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (!WAIT) begin
            r_xpt  <= w_xpt_nxt;
            r_nxpt <= ~w_xpt_nxt;
            if (r_state == S_FETCH) begin
                if (w_at_last) begin
                    case (DataIn)
                        8'hCB: r_prefix <= 2'b01;
                        8'hED: r_prefix <= 2'b10;
                        8'hDD: begin
                            r_prefix <= 2'b11;
                            r_ix     <= 1'b1;
                        end
                        8'hFD: begin
                            r_prefix <= 2'b11;
                            r_ix     <= 1'b0;
                        end
                        default: begin
                            r_op    <= DataIn;
                            r_state <= S_EXEC;
                            r_cm1   <= 1'b0;
                            r_de    <= 1'b1;
                        end
                    endcase
                end
            end else begin
                if (Pa_Ophd) begin
                    r_prefix <= 2'b00;
                    r_ix     <= 1'b0;
                end
                if (P2_Set_CM1 || w_recover) begin
                    r_state <= S_FETCH;
                    r_cm1   <= 1'b1;
                    r_de    <= 1'b0;
                end
                if (w_recover) r_ovf <= 1'b1;
            end
        end
    end
    assign XPT           = r_xpt;
    assign notXPT        = r_nxpt;
    assign CM1           = r_cm1;
    assign OP            = r_op;
    assign PREFIX        = r_prefix;
    assign IX_nIY        = r_ix;
    assign Decode_Enable = r_de;
    assign XPT_Overflow  = r_ovf;
endmodule
